truth_table_engine: RTL and testbench

Programmable, parametrised successor to the fixed four-input / ten-output sum-of-products breadboard block.
- Stores an N_IN-input, N_OUT-output truth table in registers that software can load.
- Answers single-vector lookups with one cycle of latency.
- Autonomously sweeps all 2^N_IN rows and streams each row out over a valid/ready handshake, replacing the hand-written sweep loop used to dump function tables.
- Sits between the configuration bus and the verification/display logic.

---
 rtl/truth_table_pkg.sv | 22 ++
 rtl/tt_mem.sv | 47 ++++
 rtl/truth_table_engine.sv | 110 +++++++++++
 tb/tb_truth_table_engine.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_pkg.sv
// truth_table_pkg
//   Shared definitions for the programmable truth-table engine:
//   - state_t : sweep controller states (IDLE, SWEEP, DONE)
//   - N_IN_DEFAULT / N_OUT_DEFAULT : default input width and row width
//   - depth() : number of table rows for a given input width
package truth_table_pkg;

    localparam int N_IN_DEFAULT  = 4;
    localparam int N_OUT_DEFAULT = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Table depth: one row per input combination.
    function automatic int depth(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/tt_mem.sv
// tt_mem
//   2^N_IN x N_OUT register array holding the truth table.
//   Ports:
//     clk, rst          : clock, synchronous active-high reset (clears every row)
//     we, waddr, wdata  : synchronous write port
//     lookup_addr/data  : asynchronous read port for single-vector lookups
//     sweep_addr/data   : asynchronous read port for the row sweep
module tt_mem
    import truth_table_pkg::*;
#(
    parameter int N_IN  = N_IN_DEFAULT,
    parameter int N_OUT = N_OUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [N_IN-1:0]  waddr,
    input  logic [N_OUT-1:0] wdata,
    input  logic [N_IN-1:0]  lookup_addr,
    output logic [N_OUT-1:0] lookup_data,
    input  logic [N_IN-1:0]  sweep_addr,
    output logic [N_OUT-1:0] sweep_data
);

    localparam int DEPTH = depth(N_IN);

    logic [N_OUT-1:0] rows [DEPTH];

    // NOTE: this is a flop array, not an inferred RAM, so a loop reset of every
    // entry is legal here; a RAM macro could not be cleared this way.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                // NOTE: sequential state always uses non-blocking assignment so
                // every flop samples pre-edge values; this also gives lookups
                // on the write edge the old contents (read-before-write).
                rows[i] <= '0;
            end
        end else if (we) begin
            rows[waddr] <= wdata;
        end
    end

    assign lookup_data = rows[lookup_addr];
    assign sweep_data  = rows[sweep_addr];

endmodule

// File: rtl/truth_table_engine.sv
// truth_table_engine
//   Software-loadable N_IN-input / N_OUT-output truth table with one-cycle
//   lookups and an autonomous full-table sweep streamed over valid/ready.
//   Ports:
//     clk, rst                      : clock, synchronous active-high reset
//     cfg_we, cfg_addr, cfg_data    : row write (rejected during a sweep)
//     cfg_err                       : one-cycle pulse for a rejected write
//     in_valid, in_vec              : lookup request
//     out_valid, out_vec            : lookup result, one cycle later
//     sweep_start, sweep_busy       : sweep trigger (IDLE only) / in-progress flag
//     row_valid, row_ready          : sweep stream handshake
//     row_idx, row_data             : streamed row index and contents
//     sweep_done                    : one-cycle pulse after the last row
module truth_table_engine
    import truth_table_pkg::*;
#(
    parameter int N_IN  = N_IN_DEFAULT,
    parameter int N_OUT = N_OUT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [N_IN-1:0]  cfg_addr,
    input  logic [N_OUT-1:0] cfg_data,
    output logic             cfg_err,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  in_vec,
    output logic             out_valid,
    output logic [N_OUT-1:0] out_vec,
    input  logic             sweep_start,
    output logic             sweep_busy,
    output logic             row_valid,
    input  logic             row_ready,
    output logic [N_IN-1:0]  row_idx,
    output logic [N_OUT-1:0] row_data,
    output logic             sweep_done
);

    state_t           state;
    logic [N_IN-1:0]  row_cnt;
    logic [N_OUT-1:0] lookup_data;
    logic             mem_we;

    // Writes are locked out while sweeping so the streamed table is coherent.
    assign mem_we = cfg_we && (state != SWEEP);

    tt_mem #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_mem (
        .clk         (clk),
        .rst         (rst),
        .we          (mem_we),
        .waddr       (cfg_addr),
        .wdata       (cfg_data),
        .lookup_addr (in_vec),
        .lookup_data (lookup_data),
        .sweep_addr  (row_cnt),
        .sweep_data  (row_data)
    );

    // Status outputs decode the state register directly; row_data is a read of
    // the flop array at the registered counter, so no input reaches them.
    assign row_valid  = (state == SWEEP);
    assign sweep_busy = (state == SWEEP);
    assign sweep_done = (state == DONE);
    assign row_idx    = row_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            row_cnt   <= '0;
            cfg_err   <= 1'b0;
            out_valid <= 1'b0;
            out_vec   <= '0;
        end else begin
            cfg_err   <= cfg_we && (state == SWEEP);
            out_valid <= in_valid;
            if (in_valid) begin
                out_vec <= lookup_data;
            end

            case (state)
                IDLE: begin
                    if (sweep_start) begin
                        state   <= SWEEP;
                        row_cnt <= '0;
                    end
                end
                SWEEP: begin
                    if (row_ready) begin
                        // The counter stops on the last row instead of wrapping.
                        if (row_cnt == '1) begin
                            state <= DONE;
                        end else begin
                            row_cnt <= row_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_engine.sv
// tb_truth_table_engine
//   Directed self-checking bench for truth_table_engine (N_IN=4, N_OUT=10).
//   Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_truth_table_engine;

    localparam int N_IN  = 4;
    localparam int N_OUT = 10;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             cfg_we;
    logic [N_IN-1:0]  cfg_addr;
    logic [N_OUT-1:0] cfg_data;
    logic             cfg_err;
    logic             in_valid;
    logic [N_IN-1:0]  in_vec;
    logic             out_valid;
    logic [N_OUT-1:0] out_vec;
    logic             sweep_start;
    logic             sweep_busy;
    logic             row_valid;
    logic             row_ready;
    logic [N_IN-1:0]  row_idx;
    logic [N_OUT-1:0] row_data;
    logic             sweep_done;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [N_OUT-1:0] exp_tab [DEPTH];

    truth_table_engine #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_err     (cfg_err),
        .in_valid    (in_valid),
        .in_vec      (in_vec),
        .out_valid   (out_valid),
        .out_vec     (out_vec),
        .sweep_start (sweep_start),
        .sweep_busy  (sweep_busy),
        .row_valid   (row_valid),
        .row_ready   (row_ready),
        .row_idx     (row_idx),
        .row_data    (row_data),
        .sweep_done  (sweep_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    initial begin
        int cyc;
        rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        in_valid = 1'b0; in_vec = '0; sweep_start = 1'b0; row_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) exp_tab[i] = 10'(i * 10'h041);

        // Reset state
        step(); step();
        rst = 1'b0;
        check("rst_cfg_err", cfg_err, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_vec", out_vec, 0);
        check("rst_busy", sweep_busy, 0);
        check("rst_row_valid", row_valid, 0);
        check("rst_row_idx", row_idx, 0);
        check("rst_row_data", row_data, 0);
        check("rst_done", sweep_done, 0);

        // Lookup of an empty table
        in_valid = 1'b1; in_vec = 4'd9;
        step();
        in_valid = 1'b0;
        check("lk9_valid", out_valid, 1);
        check("lk9_vec", out_vec, 10'h000);
        step();
        check("lk9_valid_drop", out_valid, 0);

        // Write then lookup
        cfg_we = 1'b1; cfg_addr = 4'd5; cfg_data = 10'h2A5;
        step();
        cfg_we = 1'b0;
        in_valid = 1'b1; in_vec = 4'd5;
        step();
        check("lk5_vec", out_vec, 10'h2A5);
        // Same-edge write and lookup: old contents
        cfg_we = 1'b1; cfg_addr = 4'd5; cfg_data = 10'h155;
        step();
        cfg_we = 1'b0;
        check("rbw_vec", out_vec, 10'h2A5);
        step();
        in_valid = 1'b0;
        check("rbw_new_vec", out_vec, 10'h155);
        step();
        check("hold_valid", out_valid, 0);
        check("hold_vec", out_vec, 10'h155);

        // Load row i = i * 0x041
        for (int i = 0; i < DEPTH; i++) begin
            cfg_we = 1'b1; cfg_addr = 4'(i); cfg_data = exp_tab[i];
            step();
        end
        cfg_we = 1'b0;

        // Full sweep with row_ready held high
        row_ready = 1'b1; sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        check("sw_busy", sweep_busy, 1);
        for (int r = 0; r < DEPTH; r++) begin
            check("sw_valid", row_valid, 1);
            check("sw_idx", row_idx, r);
            check("sw_data", row_data, exp_tab[r]);
            check("sw_no_early_done", sweep_done, 0);
            step();
        end
        check("sw_done_c17", sweep_done, 1);
        check("sw_valid_end", row_valid, 0);
        check("sw_busy_end", sweep_busy, 0);
        step();
        check("sw_done_pulse", sweep_done, 0);
        check("sw_busy_after", sweep_busy, 0);

        // Sweep with backpressure at row 7, rejected write and restart at row 3
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            check("bp_idx", row_idx, r);
            check("bp_data", row_data, exp_tab[r]);
            if (r == 4) check("err_pulse", cfg_err, 1);
            if (r == 5) check("err_once", cfg_err, 0);
            if (r == 7) begin
                row_ready = 1'b0;
                repeat (3) begin
                    step();
                    check("bp_hold_valid", row_valid, 1);
                    check("bp_hold_idx", row_idx, 7);
                    check("bp_hold_data", row_data, exp_tab[7]);
                end
                row_ready = 1'b1;
            end
            if (r == 3) begin
                cfg_we = 1'b1; cfg_addr = 4'd3; cfg_data = 10'h3FF; sweep_start = 1'b1;
            end
            step();
            cfg_we = 1'b0; sweep_start = 1'b0;
        end
        check("bp_done", sweep_done, 1);
        step();
        in_valid = 1'b1; in_vec = 4'd3;
        step();
        in_valid = 1'b0;
        check("locked_row3", out_vec, exp_tab[3]);

        // Reset in the middle of a sweep
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        repeat (9) step();
        check("mid_idx9", row_idx, 9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", row_valid, 0);
        check("mid_rst_busy", sweep_busy, 0);
        check("mid_rst_done", sweep_done, 0);
        step();
        check("mid_rst_no_done", sweep_done, 0);
        in_valid = 1'b1; in_vec = 4'd5;
        step();
        in_valid = 1'b0;
        check("mid_rst_cleared", out_vec, 0);

        // New sweep begins at row 0 and completes
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        check("re_valid", row_valid, 1);
        check("re_idx0", row_idx, 0);
        check("re_data0", row_data, 0);
        cyc = 0;
        while (!sweep_done && cyc < 40) begin
            step();
            cyc++;
        end
        check("re_done_seen", sweep_done, 1);
        check("re_cycles", cyc, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
